// File: rtl/uart_fifo_link.sv
// Full-duplex UART with per-direction show-ahead FIFOs, optional parity, sticky line-error
// flags and an internal echo path that moves received words straight into the TX FIFO.
module uart_fifo_link #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned BAUD_RATE  = 115_200,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter bit          PARITY_EN  = 1'b0,
  parameter bit          PARITY_ODD = 1'b0
) (
  input  logic                              clk_i,
  input  logic                              reset_ni,
  input  logic                              ena_i,
  input  logic                              rx_signal_i,
  output logic                              tx_signal_o,
  input  logic [DATA_WIDTH-1:0]             tx_data_i,
  input  logic                              tx_valid_i,
  output logic                              tx_ready_o,
  output logic [DATA_WIDTH-1:0]             rx_data_o,
  output logic                              rx_valid_o,
  input  logic                              rx_ready_i,
  input  logic                              loopback_en_i,
  input  logic                              err_clear_i,
  output logic                              rx_frame_err_o,
  output logic                              rx_parity_err_o,
  output logic                              rx_overrun_o,
  output logic                              tx_busy_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   tx_level_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   rx_level_o
);

  localparam int unsigned Div = CLK_FREQ / BAUD_RATE;
  localparam int unsigned CW  = $clog2(Div);
  localparam int unsigned AW  = $clog2(FIFO_DEPTH);
  localparam int unsigned LW  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned BW  = $clog2(DATA_WIDTH);

  localparam logic [CW-1:0] BitLast  = CW'(Div - 1);
  localparam logic [CW-1:0] HalfLast = CW'(Div / 2 - 1);
  localparam logic [BW-1:0] DataLast = BW'(DATA_WIDTH - 1);
  localparam logic [LW-1:0] LevelFull = LW'(FIFO_DEPTH);

  typedef enum logic [2:0] {TxIdle, TxStart, TxData, TxParity, TxStop} tx_state_e;
  typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxParity, RxStop, RxWaitHigh} rx_state_e;

  // ---------------------------------------------------------------------------------------
  // Handshake and FIFO control
  // ---------------------------------------------------------------------------------------
  logic                  init_q;
  logic [DATA_WIDTH-1:0] tx_mem_q [FIFO_DEPTH];
  logic [AW-1:0]         tx_wr_q, tx_rd_q;
  logic [LW-1:0]         tx_cnt_q;
  logic [DATA_WIDTH-1:0] rx_mem_q [FIFO_DEPTH];
  logic [AW-1:0]         rx_wr_q, rx_rd_q;
  logic [LW-1:0]         rx_cnt_q;

  logic tx_full, tx_empty, rx_full, rx_empty;
  logic tx_accept, lb_move, tx_push, tx_pop, tx_load;
  logic rx_push, rx_pop, rx_word_ok, overrun_ev;
  logic [DATA_WIDTH-1:0] tx_head, rx_head, tx_wdata, rx_word;

  assign tx_full  = (tx_cnt_q == LevelFull);
  assign tx_empty = (tx_cnt_q == '0);
  assign rx_full  = (rx_cnt_q == LevelFull);
  assign rx_empty = (rx_cnt_q == '0);
  assign tx_head  = tx_mem_q[tx_rd_q];
  assign rx_head  = rx_mem_q[rx_rd_q];

  assign tx_ready_o = ena_i & init_q & ~tx_full & ~loopback_en_i;
  assign tx_accept  = tx_valid_i & tx_ready_o;
  assign lb_move    = ena_i & loopback_en_i & ~rx_empty & ~tx_full;
  assign tx_push    = tx_accept | lb_move;
  assign tx_wdata   = lb_move ? rx_head : tx_data_i;
  assign tx_pop     = ena_i & tx_load;

  assign rx_pop     = lb_move | (ena_i & ~loopback_en_i & ~rx_empty & rx_ready_i);
  // A full FIFO still takes the word when the head leaves on the same edge.
  assign rx_push    = ena_i & rx_word_ok & (~rx_full | rx_pop);
  assign overrun_ev = ena_i & rx_word_ok & rx_full & ~rx_pop;

  assign rx_data_o  = rx_head;
  assign rx_valid_o = ~rx_empty & ~loopback_en_i;
  assign tx_level_o = tx_cnt_q;
  assign rx_level_o = rx_cnt_q;

  // tx_ready stays low until the first edge after reset release.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) init_q <= 1'b0;
    else           init_q <= 1'b1;
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) tx_mem_q[i] <= '0;
      tx_wr_q  <= '0;
      tx_rd_q  <= '0;
      tx_cnt_q <= '0;
    end else begin
      if (tx_push) begin
        tx_mem_q[tx_wr_q] <= tx_wdata;
        tx_wr_q           <= tx_wr_q + AW'(1);
      end
      if (tx_pop) tx_rd_q <= tx_rd_q + AW'(1);
      if (tx_push && !tx_pop)      tx_cnt_q <= tx_cnt_q + LW'(1);
      else if (!tx_push && tx_pop) tx_cnt_q <= tx_cnt_q - LW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) rx_mem_q[i] <= '0;
      rx_wr_q  <= '0;
      rx_rd_q  <= '0;
      rx_cnt_q <= '0;
    end else begin
      if (rx_push) begin
        rx_mem_q[rx_wr_q] <= rx_word;
        rx_wr_q           <= rx_wr_q + AW'(1);
      end
      if (rx_pop) rx_rd_q <= rx_rd_q + AW'(1);
      if (rx_push && !rx_pop)      rx_cnt_q <= rx_cnt_q + LW'(1);
      else if (!rx_push && rx_pop) rx_cnt_q <= rx_cnt_q - LW'(1);
    end
  end

  // ---------------------------------------------------------------------------------------
  // Transmitter
  // ---------------------------------------------------------------------------------------
  tx_state_e             tx_state_q, tx_state_d;
  logic [CW-1:0]         tx_baud_q, tx_baud_d;
  logic [BW-1:0]         tx_bit_q, tx_bit_d;
  logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic                  tx_par_q, tx_par_d;
  logic                  tx_line_q, tx_line_d;
  logic                  tx_bit_end;

  assign tx_bit_end  = (tx_baud_q == BitLast);
  assign tx_signal_o = tx_line_q;
  assign tx_busy_o   = (tx_state_q != TxIdle) | ~tx_empty;

  // The line register follows the current state, so the output lags the FSM by one clock.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_baud_d  = tx_baud_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    tx_line_d  = tx_line_q;
    tx_load    = 1'b0;
    unique case (tx_state_q)
      TxIdle: begin
        tx_line_d = 1'b1;
        tx_load   = ~tx_empty;
      end
      TxStart: begin
        tx_line_d = 1'b0;
        if (tx_bit_end) begin
          tx_state_d = TxData;
          tx_baud_d  = '0;
          tx_bit_d   = '0;
        end else begin
          tx_baud_d = tx_baud_q + CW'(1);
        end
      end
      TxData: begin
        tx_line_d = tx_shift_q[0];
        if (tx_bit_end) begin
          tx_baud_d  = '0;
          tx_shift_d = tx_shift_q >> 1;
          if (tx_bit_q == DataLast) tx_state_d = PARITY_EN ? TxParity : TxStop;
          else                      tx_bit_d   = tx_bit_q + BW'(1);
        end else begin
          tx_baud_d = tx_baud_q + CW'(1);
        end
      end
      TxParity: begin
        tx_line_d = tx_par_q;
        if (tx_bit_end) begin
          tx_state_d = TxStop;
          tx_baud_d  = '0;
        end else begin
          tx_baud_d = tx_baud_q + CW'(1);
        end
      end
      TxStop: begin
        tx_line_d = 1'b1;
        if (tx_bit_end) begin
          if (!tx_empty) tx_load    = 1'b1;
          else           tx_state_d = TxIdle;
        end else begin
          tx_baud_d = tx_baud_q + CW'(1);
        end
      end
      default: tx_state_d = TxIdle;
    endcase
    if (tx_load) begin
      tx_state_d = TxStart;
      tx_baud_d  = '0;
      tx_shift_d = tx_head;
      tx_par_d   = ^tx_head ^ PARITY_ODD;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      tx_state_q <= TxIdle;
      tx_baud_q  <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      tx_line_q  <= 1'b1;
    end else if (ena_i) begin
      tx_state_q <= tx_state_d;
      tx_baud_q  <= tx_baud_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_par_q   <= tx_par_d;
      tx_line_q  <= tx_line_d;
    end
  end

  // ---------------------------------------------------------------------------------------
  // Receiver
  // ---------------------------------------------------------------------------------------
  rx_state_e             rx_state_q, rx_state_d;
  logic [1:0]            rx_sync_q;
  logic [CW-1:0]         rx_baud_q, rx_baud_d;
  logic [BW-1:0]         rx_bit_q, rx_bit_d;
  logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic                  rx_bad_q, rx_bad_d;
  logic                  rx_s, rx_bit_end, frame_ev, parity_ev;
  logic                  frame_err_q, parity_err_q, overrun_q;

  assign rx_s       = rx_sync_q[1];
  assign rx_bit_end = (rx_baud_q == BitLast);
  assign rx_word    = rx_shift_q;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_baud_d  = rx_baud_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_bad_d   = rx_bad_q;
    rx_word_ok = 1'b0;
    frame_ev   = 1'b0;
    parity_ev  = 1'b0;
    unique case (rx_state_q)
      RxIdle: begin
        if (!rx_s) begin
          rx_state_d = RxStart;
          rx_baud_d  = '0;
        end
      end
      RxStart: begin
        if (rx_baud_q == HalfLast) begin
          rx_baud_d = '0;
          if (rx_s) begin
            rx_state_d = RxIdle;
          end else begin
            rx_state_d = RxData;
            rx_bit_d   = '0;
            rx_bad_d   = 1'b0;
          end
        end else begin
          rx_baud_d = rx_baud_q + CW'(1);
        end
      end
      RxData: begin
        if (rx_bit_end) begin
          rx_baud_d  = '0;
          rx_shift_d = {rx_s, rx_shift_q[DATA_WIDTH-1:1]};
          if (rx_bit_q == DataLast) rx_state_d = PARITY_EN ? RxParity : RxStop;
          else                      rx_bit_d   = rx_bit_q + BW'(1);
        end else begin
          rx_baud_d = rx_baud_q + CW'(1);
        end
      end
      RxParity: begin
        if (rx_bit_end) begin
          rx_baud_d  = '0;
          rx_state_d = RxStop;
          if (rx_s != (^rx_shift_q ^ PARITY_ODD)) begin
            rx_bad_d  = 1'b1;
            parity_ev = 1'b1;
          end
        end else begin
          rx_baud_d = rx_baud_q + CW'(1);
        end
      end
      RxStop: begin
        if (rx_bit_end) begin
          rx_baud_d = '0;
          if (!rx_s) begin
            frame_ev   = 1'b1;
            rx_state_d = RxWaitHigh;
          end else begin
            rx_word_ok = ~rx_bad_q;
            rx_state_d = RxIdle;
          end
        end else begin
          rx_baud_d = rx_baud_q + CW'(1);
        end
      end
      RxWaitHigh: begin
        if (rx_s) rx_state_d = RxIdle;
      end
      default: rx_state_d = RxIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      rx_sync_q  <= 2'b11;
      rx_state_q <= RxIdle;
      rx_baud_q  <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_bad_q   <= 1'b0;
    end else if (ena_i) begin
      rx_sync_q  <= {rx_sync_q[0], rx_signal_i};
      rx_state_q <= rx_state_d;
      rx_baud_q  <= rx_baud_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_bad_q   <= rx_bad_d;
    end
  end

  // A new error event outranks a clear in the same cycle.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else if (ena_i) begin
      frame_err_q  <= frame_ev   | (frame_err_q  & ~err_clear_i);
      parity_err_q <= parity_ev  | (parity_err_q & ~err_clear_i);
      overrun_q    <= overrun_ev | (overrun_q    & ~err_clear_i);
    end
  end

  assign rx_frame_err_o  = frame_err_q;
  assign rx_parity_err_o = parity_err_q;
  assign rx_overrun_o    = overrun_q;

endmodule

// File: tb/tb_uart_fifo_link.sv
// Directed bench for uart_fifo_link: one 8N1 instance and one 8E1 instance, both at
// 16 clocks per bit, with the TX line of the 8N1 instance logged every cycle.
module tb_uart_fifo_link;

  localparam int Div  = 16;
  localparam int LogN = 16384;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b1;
  logic ena   = 1'b1;

  logic       rx_line = 1'b1, tx_line, tx_valid = 1'b0, tx_ready, rx_valid, rx_ready = 1'b0;
  logic       loopback = 1'b0, err_clear = 1'b0;
  logic [7:0] tx_data = '0, rx_data;
  logic       frame_err, parity_err, overrun, tx_busy;
  logic [2:0] tx_level, rx_level;

  logic       rx_line_p = 1'b1, tx_line_p, tx_ready_p, rx_valid_p;
  logic [7:0] rx_data_p;
  logic       frame_err_p, parity_err_p, overrun_p, tx_busy_p;
  logic [2:0] tx_level_p, rx_level_p;

  uart_fifo_link #(
    .DATA_WIDTH(8), .CLK_FREQ(16), .BAUD_RATE(1), .FIFO_DEPTH(4),
    .PARITY_EN(1'b0), .PARITY_ODD(1'b0)
  ) dut (
    .clk_i(clk), .reset_ni(rst_n), .ena_i(ena), .rx_signal_i(rx_line),
    .tx_signal_o(tx_line), .tx_data_i(tx_data), .tx_valid_i(tx_valid),
    .tx_ready_o(tx_ready), .rx_data_o(rx_data), .rx_valid_o(rx_valid),
    .rx_ready_i(rx_ready), .loopback_en_i(loopback), .err_clear_i(err_clear),
    .rx_frame_err_o(frame_err), .rx_parity_err_o(parity_err), .rx_overrun_o(overrun),
    .tx_busy_o(tx_busy), .tx_level_o(tx_level), .rx_level_o(rx_level)
  );

  uart_fifo_link #(
    .DATA_WIDTH(8), .CLK_FREQ(16), .BAUD_RATE(1), .FIFO_DEPTH(4),
    .PARITY_EN(1'b1), .PARITY_ODD(1'b0)
  ) dut_p (
    .clk_i(clk), .reset_ni(rst_n), .ena_i(ena), .rx_signal_i(rx_line_p),
    .tx_signal_o(tx_line_p), .tx_data_i(8'h00), .tx_valid_i(1'b0),
    .tx_ready_o(tx_ready_p), .rx_data_o(rx_data_p), .rx_valid_o(rx_valid_p),
    .rx_ready_i(1'b0), .loopback_en_i(1'b0), .err_clear_i(1'b0),
    .rx_frame_err_o(frame_err_p), .rx_parity_err_o(parity_err_p),
    .rx_overrun_o(overrun_p), .tx_busy_o(tx_busy_p), .tx_level_o(tx_level_p),
    .rx_level_o(rx_level_p)
  );

  int   cyc = 0;
  int   lb_leak = 0;
  logic txlog [LogN];

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (cyc < LogN) txlog[cyc] <= tx_line;
  always @(negedge clk) if (loopback && rx_valid) lb_leak <= lb_leak + 1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_line(input bit which, input logic v);
    if (which) rx_line_p = v;
    else       rx_line   = v;
  endtask

  // Drives one frame, each bit held for Div clocks, then leaves the line at post.
  task automatic send_rx(input bit which, input logic [7:0] d, input bit use_par,
                         input logic par, input logic stop, input logic post);
    logic [10:0] bits;
    int          nb;
    bits      = '1;
    bits[0]   = 1'b0;
    bits[8:1] = d;
    if (use_par) begin
      bits[9]  = par;
      bits[10] = stop;
      nb       = 11;
    end else begin
      bits[9] = stop;
      nb      = 10;
    end
    for (int b = 0; b < nb; b++) begin
      set_line(which, bits[b]);
      tick(Div);
    end
    set_line(which, post);
  endtask

  task automatic wait_idle(input string tag, input int maxc);
    int n;
    n = 0;
    while (tx_busy !== 1'b0 && n < maxc) begin
      @(negedge clk);
      n++;
    end
    check(tag, tx_busy, 1'b0);
  endtask

  function automatic int find_low(input int from, input int to);
    for (int i = from; i < to && i < LogN; i++) if (txlog[i] === 1'b0) return i;
    return -1;
  endfunction

  // Mid-bit samples of a logged frame: {stop, data[7:0], start}.
  function automatic logic [9:0] frame_at(input int s);
    logic [9:0] f;
    for (int b = 0; b < 10; b++) f[b] = txlog[s + 8 + Div * b];
    return f;
  endfunction

  initial begin
    logic [9:0] exp_f;
    int         errs, base, s, n_acc, guard;
    int         acc_cyc [6];
    bit         full_seen, rdy;

    // Reset state
    #2 rst_n = 1'b0;
    tick(3);
    check("rst tx_line", tx_line, 1'b1);
    check("rst tx_ready", tx_ready, 1'b0);
    check("rst rx_valid", rx_valid, 1'b0);
    check("rst rx_data", rx_data, 8'h00);
    check("rst flags", {frame_err, parity_err, overrun}, 3'b000);
    check("rst levels", {tx_level, rx_level}, 6'd0);
    check("rst tx_busy", tx_busy, 1'b0);
    rst_n = 1'b1;
    #1 check("tx_ready before first edge", tx_ready, 1'b0);
    @(negedge clk);
    check("tx_ready after first edge", tx_ready, 1'b1);
    ena = 1'b0;
    #1 check("tx_ready with ena low", tx_ready, 1'b0);
    ena = 1'b1;
    @(negedge clk);

    // 1: single 0xA5 frame, start bit two edges after acceptance
    tx_data  = 8'hA5;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    check("t1 level after push", tx_level, 3'd1);
    @(negedge clk);
    check("t1 line high one edge after accept", tx_line, 1'b1);
    exp_f = {1'b1, 8'hA5, 1'b0};
    for (int b = 0; b < 10; b++) begin
      errs = 0;
      for (int c = 0; c < Div; c++) begin
        @(negedge clk);
        if (tx_line !== exp_f[b]) errs++;
      end
      check($sformatf("t1 bit%0d samples off", b), errs, 0);
    end
    check("t1 tx_busy after frame", tx_busy, 1'b0);
    check("t1 level after frame", tx_level, 3'd0);
    tick(4);

    // 2: six words held on tx_valid, FIFO depth 4
    base      = cyc;
    tx_data   = 8'h01;
    tx_valid  = 1'b1;
    n_acc     = 0;
    guard     = 0;
    full_seen = 1'b0;
    while (n_acc < 6 && guard < 600) begin
      rdy = tx_ready;
      if (rdy) acc_cyc[n_acc] = cyc;
      if (!rdy && !full_seen) begin
        full_seen = 1'b1;
        check("t2 accepted before ready low", n_acc, 5);
        check("t2 level when full", tx_level, 3'd4);
      end
      @(negedge clk);
      guard++;
      if (rdy) begin
        n_acc++;
        tx_data = 8'(n_acc + 1);
      end
    end
    tx_valid = 1'b0;
    check("t2 all six accepted", n_acc, 6);
    check("t2 sixth accept delay", acc_cyc[5] - acc_cyc[0], 162);
    wait_idle("t2 drained", 1500);
    check("t2 level drained", tx_level, 3'd0);
    tick(20);
    s = find_low(base, cyc);
    check("t2 first start latency", s - acc_cyc[0], 3);
    if (s < 0) s = 0;
    for (int k = 0; k < 6; k++)
      check($sformatf("t2 frame%0d", k), frame_at(s + 160 * k), {1'b1, 8'(k + 1), 1'b0});
    check("t2 idle after last frame", txlog[s + 960 + 8], 1'b1);

    // 3: even parity on the second instance
    send_rx(1'b1, 8'h3C, 1'b1, 1'b0, 1'b1, 1'b1);
    check("t3 rx_valid good parity", rx_valid_p, 1'b1);
    check("t3 rx_data good parity", rx_data_p, 8'h3C);
    check("t3 no parity err yet", parity_err_p, 1'b0);
    tick(4);
    send_rx(1'b1, 8'h3C, 1'b1, 1'b1, 1'b1, 1'b1);
    check("t3 parity err set", parity_err_p, 1'b1);
    check("t3 bad word dropped", rx_level_p, 3'd1);
    check("t3 frame err clean", frame_err_p, 1'b0);

    // 4: stop bit 0, line held low, then recovery
    tick(4);
    send_rx(1'b0, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
    check("t4 frame err set", frame_err, 1'b1);
    check("t4 level after bad stop", rx_level, 3'd0);
    check("t4 rx_valid after bad stop", rx_valid, 1'b0);
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
    check("t4 frame err cleared", frame_err, 1'b0);
    send_rx(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    check("t4 low-line frame no flag", frame_err, 1'b0);
    check("t4 low-line frame no push", rx_level, 3'd0);
    rx_line = 1'b1;
    tick(40);
    send_rx(1'b0, 8'h3A, 1'b0, 1'b0, 1'b1, 1'b1);
    check("t4 level after recovery", rx_level, 3'd1);
    check("t4 data after recovery", rx_data, 8'h3A);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    check("t4 level after pop", rx_level, 3'd0);

    // 5: overrun with consumer stalled
    tick(4);
    for (int k = 0; k < 4; k++) send_rx(1'b0, 8'(8'h10 + k), 1'b0, 1'b0, 1'b1, 1'b1);
    check("t5 level full", rx_level, 3'd4);
    check("t5 no overrun yet", overrun, 1'b0);
    send_rx(1'b0, 8'h14, 1'b0, 1'b0, 1'b1, 1'b1);
    check("t5 level still full", rx_level, 3'd4);
    check("t5 overrun set", overrun, 1'b1);
    check("t5 head", rx_data, 8'h10);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("t5 pop%0d data", k), rx_data, 8'(8'h10 + k));
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
    end
    check("t5 empty after pops", {rx_valid, rx_level}, 4'd0);
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
    check("t5 overrun cleared", overrun, 1'b0);

    // 6: loopback echo, then reset in the middle of a frame
    loopback = 1'b1;
    @(negedge clk);
    check("t6 tx_ready blocked in loopback", tx_ready, 1'b0);
    base = cyc;
    send_rx(1'b0, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b1);
    check("t6 rx_valid forced low", rx_valid, 1'b0);
    check("t6 word left rx fifo", rx_level, 3'd0);
    wait_idle("t6 echo done", 400);
    tick(4);
    s = find_low(base, cyc);
    check("t6 echo start found", s >= 0, 1'b1);
    if (s < 0) s = 0;
    check("t6 echo frame", frame_at(s), {1'b1, 8'h5A, 1'b0});
    check("t6 rx_valid never high", lb_leak, 0);
    loopback = 1'b0;
    @(negedge clk);

    send_rx(1'b0, 8'h77, 1'b0, 1'b0, 1'b1, 1'b1);
    tx_data  = 8'h11;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_data = 8'h22;
    @(negedge clk);
    tx_valid = 1'b0;
    @(negedge clk);
    check("t6 mid-frame line low", tx_line, 1'b0);
    check("t6 pre-reset levels", {tx_level, rx_level}, {3'd1, 3'd1});
    #2 rst_n = 1'b0;
    #1;
    check("t6 reset line high", tx_line, 1'b1);
    check("t6 reset levels", {tx_level, rx_level}, 6'd0);
    check("t6 reset rx side", {rx_valid, rx_data}, 9'd0);
    check("t6 reset tx_busy", tx_busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_fifo_link.md
Name: uart_fifo_link

Overview:
Parametrised full-duplex UART link, successor to the fixed 8N1 single-word UART. Adds per-direction FIFO buffering, optional parity, sticky line-error flags, an internal loopback (echo) mode and FIFO level reporting. Sits behind the TinyTapeout top wrapper between the uio pins and the Basys3-side host logic.

Parameters:
DATA_WIDTH, 8, payload bits per frame (5..9)
CLK_FREQ, 50_000_000, clock frequency in Hz
BAUD_RATE, 115_200, line rate; bit period DIV = CLK_FREQ/BAUD_RATE, truncated, must be at least 4
FIFO_DEPTH, 4, entries per FIFO, power of two, at least 2
PARITY_EN, 0, 1 = parity bit after the data bits
PARITY_ODD, 0, 1 = odd parity, 0 = even; ignored when PARITY_EN=0

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
ena  in  1  global enable; 0 freezes all state
rx_signal  in  1  serial input, asynchronous to clk
tx_signal  out  1  serial output, idle high
tx_data  in  DATA_WIDTH  word to transmit
tx_valid  in  1  tx_data valid
tx_ready  out  1  TX FIFO can accept
rx_data  out  DATA_WIDTH  RX FIFO head
rx_valid  out  1  RX FIFO non-empty
rx_ready  in  1  consumer pops head
loopback_en  in  1  echo received words into TX FIFO internally
err_clear  in  1  clears sticky error flags
rx_frame_err  out  1  sticky: stop bit sampled 0
rx_parity_err  out  1  sticky: parity mismatch
rx_overrun  out  1  sticky: word dropped, RX FIFO full
tx_busy  out  1  TX FSM not IDLE or TX FIFO non-empty
tx_level  out  $clog2(FIFO_DEPTH+1)  TX FIFO occupancy
rx_level  out  $clog2(FIFO_DEPTH+1)  RX FIFO occupancy

Behaviour:
- Reset (asynchronous, any time, including mid-frame): tx_signal=1, tx_ready=0 until the first edge after release, rx_valid=0, rx_data=0, all error flags 0, levels 0, tx_busy=0, both FIFOs empty, both FSMs IDLE, synchroniser flops =1. Any partial frame is abandoned.
- ena=0: counters, FSMs and FIFOs hold; tx_signal holds; tx_ready=0; pops ignored.
- Frame: start bit 0, DATA_WIDTH bits LSB first, optional parity bit, one stop bit 1. Each bit lasts DIV clocks.
- TX handshake: accept when tx_valid && tx_ready. tx_ready = ena && !tx_full && !loopback_en.
- TX FSM IDLE->START->DATA->(PARITY)->STOP->IDLE. IDLE pops the FIFO when non-empty. tx_signal is registered. When the FIFO was empty and the FSM idle, the start bit appears on the second rising edge after the accepting edge. Queued words go out back-to-back, with no idle gap after the stop bit.
- RX path: 2-flop synchroniser. IDLE waits for a synced 0.
- RX START: sample at DIV/2. If the sample is 1, the start was false: return to IDLE with no flag.
- RX DATA/PARITY/STOP: sample every DIV clocks after the start-bit midpoint.
- RX STOP=0: set rx_frame_err, discard the word, go to WAIT_HIGH, and return to IDLE only when the synced line is 1.
- RX parity mismatch: set rx_parity_err and discard the word.
- Good word: push to the RX FIFO. If the FIFO is full with no same-cycle pop, drop the word and set rx_overrun. A push and a pop in the same cycle with the FIFO full both succeed.
- RX FIFO is show-ahead: rx_data = head and rx_valid = !empty. Pop on rx_valid && rx_ready.
- Loopback: the external rx_valid is forced 0. The RX head moves into the TX FIFO whenever the TX FIFO is not full, one word per clock.
- err_clear clears all sticky flags. An error event in the same cycle wins, and its flag is set.
- tx_level and rx_level are updated on the same edge as the push or pop.

Test Plan:
1. CLK_FREQ=16, BAUD_RATE=1 (DIV=16), no parity. Write 0xA5 once. Expect tx_signal low for 16 clocks starting 2 edges after acceptance, then 1,0,1,0,0,1,0,1 at 16 clocks each, then high. Frame length is 160 clocks and tx_busy=0 afterwards.
2. FIFO_DEPTH=4. Hold tx_valid for words 0x01..0x06. Expect 5 words accepted before tx_ready=0, tx_level=4, the 6th accepted after the first frame ends, six frames in order with no idle gap, and tx_level back to 0.
3. PARITY_EN=1, even. Drive frame 0x3C with parity 0. Expect rx_valid=1, rx_data=0x3C. Repeat with parity 1: no push, rx_parity_err=1.
4. Drive frame 0x55 with stop bit 0. Expect rx_frame_err=1 and rx_level=0. A frame driven while the line is still low is ignored, and the next frame after the line goes high is received.
5. rx_ready=0, five good frames 0x10..0x14. Expect rx_level=4, rx_overrun=1, head 0x10, pops yielding 0x10..0x13. Then err_clear=1 gives rx_overrun=0.
6. loopback_en=1. Inject 0x5A on rx_signal. Expect 0x5A retransmitted on tx_signal and rx_valid held 0. Assert reset_n=0 mid-frame: tx_signal=1 immediately and all levels 0.
